sequence_checker: RTL and testbench

- Player-response stage that sits downstream of random_generator and graphics_control.
- After the control FSM finishes flashing a round, it pulses start. This block then accepts debounced KEY presses and compares each one against the latched 2-bit tile sequence.
- Reports pass/fail and keeps a running score.
- Emits a press strobe and tile number so graphics_datapath can flash the tile the player pressed.

---
 rtl/sequence_checker.sv | 167 ++++++++++++++++
 tb/tb_sequence_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// Player-response stage: debounces the four pushbuttons, checks each press
// against the latched tile sequence, and reports pass/fail plus a running score.
module sequence_checker #(
  parameter int SEQ_LEN         = 9,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*SEQ_LEN-1:0]   seq,
  input  logic [3:0]             length,
  input  logic [3:0]             key_n,
  output logic                   busy,
  output logic [3:0]             cur_index,
  output logic                   press_valid,
  output logic [1:0]             press_tile,
  output logic                   pass,
  output logic                   fail,
  output logic [7:0]             score
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] MAX_LEN = 4'(SEQ_LEN);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WAIT_PRESS   = 3'd1;
  localparam logic [2:0] WAIT_RELEASE = 3'd2;
  localparam logic [2:0] PASS         = 3'd3;
  localparam logic [2:0] FAIL         = 3'd4;

  logic [2:0]           state;
  logic [3:0]           sync1, sync2;
  logic [3:0]           db_n;
  logic [DW-1:0]        db_cnt [4];
  logic [3:0]           deb, deb_prev;
  logic [2*SEQ_LEN-1:0] seq_q;
  logic [3:0]           eff_len;
  logic [TW-1:0]        tcnt;

  logic       press_evt;
  logic       single;
  logic [1:0] tile;
  logic [1:0] exp_tile;
  logic       timeout;
  logic       last;

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0)
      return 4'd1;
    else if (l > MAX_LEN)
      return MAX_LEN;
    else
      return l;
  endfunction

  // Debounce state is kept active-low so its reset value matches released keys.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      db_n     <= '1;
      deb_prev <= '0;
      for (int unsigned k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int unsigned k = 0; k < 4; k++) begin
        if (sync2[k] != db_n[k]) begin
          if (db_cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_n[k]   <= sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign deb = ~db_n;

  always_comb begin
    tile = 2'd0;
    for (int unsigned k = 0; k < 4; k++)
      if (deb[k]) tile = 2'(k);
  end

  // A press event needs a fully released vector the cycle before, so keys
  // held across WAIT_PRESS entry are ignored until everything is let go.
  assign press_evt = (state == WAIT_PRESS) && (deb_prev == 4'd0) && (deb != 4'd0);
  assign single    = $onehot(deb);
  assign exp_tile  = seq_q[{cur_index, 1'b0} +: 2];
  assign timeout   = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign last      = (cur_index == eff_len - 4'd1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      seq_q       <= '0;
      eff_len     <= '0;
      tcnt        <= '0;
      cur_index   <= '0;
      press_valid <= 1'b0;
      press_tile  <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      score       <= '0;
    end else begin
      press_valid <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seq_q     <= seq;
            eff_len   <= clamp_len(length);
            cur_index <= '0;
            tcnt      <= '0;
            state     <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          tcnt <= tcnt + 1'b1;
          if (press_evt) begin
            if (single) begin
              press_valid <= 1'b1;
              press_tile  <= tile;
              state       <= (tile == exp_tile) ? WAIT_RELEASE : FAIL;
            end else begin
              state <= FAIL;
            end
          end else if (timeout) begin
            state <= FAIL;
          end
        end
        WAIT_RELEASE: begin
          if (deb == 4'd0) begin
            if (last) begin
              state <= PASS;
            end else begin
              cur_index <= cur_index + 4'd1;
              tcnt      <= '0;
              state     <= WAIT_PRESS;
            end
          end
        end
        PASS: begin
          pass  <= 1'b1;
          if (score != 8'hFF) score <= score + 8'd1;
          state <= IDLE;
        end
        FAIL: begin
          fail  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench for sequence_checker: expected presses and round results are
// queued as stimulus is driven and compared as the DUT emits them.
module tb_sequence_checker;

  localparam int SEQ_LEN = 9;
  localparam int DEB     = 4;
  localparam int TO      = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] seq;
  logic [3:0]  length;
  logic [3:0]  key_n;
  logic        busy;
  logic [3:0]  cur_index;
  logic        press_valid;
  logic [1:0]  press_tile;
  logic        pass;
  logic        fail;
  logic [7:0]  score;

  always #5 clock = ~clock;

  sequence_checker #(
    .SEQ_LEN(SEQ_LEN),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .seq(seq),
    .length(length),
    .key_n(key_n),
    .busy(busy),
    .cur_index(cur_index),
    .press_valid(press_valid),
    .press_tile(press_tile),
    .pass(pass),
    .fail(fail),
    .score(score)
  );

  typedef struct {
    logic [1:0] kind;   // {pass, fail}
    logic [7:0] score;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_press [$];
  res_t       exp_res   [$];
  int   cyc = 0;
  int   pv_count = 0, pass_count = 0, fail_count = 0;
  int   pv_cyc = 0, fail_cyc = 0;
  int   model_score = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    res_t r;
    if (!reset) begin
      if (press_valid) begin
        pv_count++;
        pv_cyc = cyc;
        if (exp_press.size() == 0) check("press_unexpected", 32'(press_valid), 0);
        else check("press_tile", 32'(press_tile), 32'(exp_press.pop_front()));
      end
      if (pass || fail) begin
        if (pass) pass_count++;
        if (fail) begin fail_count++; fail_cyc = cyc; end
        if (exp_res.size() == 0) check("result_unexpected", 32'({pass, fail}), 0);
        else begin
          r = exp_res.pop_front();
          check("result_kind", 32'({pass, fail}), 32'(r.kind));
          check("result_score", 32'(score), 32'(r.score));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [17:0] s, input logic [3:0] l);
    seq = s; length = l; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic press_key(input int k, input int hold, input int rel);
    key_n[k] = 1'b0;
    step(hold);
    key_n[k] = 1'b1;
    step(rel);
  endtask

  task automatic expect_pass();
    model_score = (model_score < 255) ? model_score + 1 : 255;
    exp_res.push_back('{2'b10, 8'(model_score)});
  endtask

  task automatic expect_fail();
    exp_res.push_back('{2'b01, 8'(model_score)});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin step(1); n++; end
    step(2);
    check(tag, 32'(busy), 0);
    check({tag, "_queue"}, 32'(exp_press.size() + exp_res.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, n, entry;
    logic [1:0]  tiles9 [9];
    logic [17:0] s9;

    reset = 1'b1; start = 1'b0; seq = '0; length = '0; key_n = '1;
    step(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_index", 32'(cur_index), 0);
    check("rst_pv", 32'(press_valid), 0);
    check("rst_tile", 32'(press_tile), 0);
    check("rst_pass_fail", 32'({pass, fail}), 0);
    check("rst_score", 32'(score), 0);
    reset = 1'b0;
    step(3);

    // Correct 3-tile round (tiles 1,3,2) with a start pulse mid-round that must be ignored
    exp_press.push_back(2'd1); exp_press.push_back(2'd3); exp_press.push_back(2'd2);
    expect_pass();
    pulse_start(18'b10_11_01, 4'd3);
    press_key(1, 10, 10);
    pulse_start(18'h0, 4'd1);
    press_key(3, 10, 10);
    press_key(2, 10, 10);
    wait_idle("round_idle");
    check("round_score", 32'(score), 1);

    // Wrong first tile: press then fail on the following cycle
    exp_press.push_back(2'd0);
    expect_fail();
    pulse_start(18'b10_11_01, 4'd3);
    press_key(0, 10, 10);
    wait_idle("wrong_idle");
    check("wrong_fail_latency", 32'(fail_cyc - pv_cyc), 1);
    check("wrong_score", 32'(score), 1);

    // Bounce on KEY2 produces no event; a steady hold produces exactly one
    exp_press.push_back(2'd2);
    expect_pass();
    pulse_start(18'b10, 4'd1);
    p0 = pv_count;
    for (int i = 0; i < 5; i++) begin
      key_n[2] = 1'b0; step(2);
      key_n[2] = 1'b1; step(2);
    end
    step(4);
    check("bounce_quiet", 32'(pv_count), 32'(p0));
    key_n[2] = 1'b0; step(10);
    check("bounce_one_press", 32'(pv_count), 32'(p0 + 1));
    key_n[2] = 1'b1; step(10);
    wait_idle("bounce_idle");

    // Timeout: state reaches FAIL 100 cycles after entry, fail output one cycle later
    expect_fail();
    f0 = fail_count;
    pulse_start(18'h0, 4'd1);
    entry = cyc;
    n = 0;
    while (fail_count == f0 && n < 200) begin step(1); n++; end
    check("timeout_seen", 32'(fail_count), 32'(f0 + 1));
    check("timeout_latency", 32'(fail_cyc - entry), 101);
    wait_idle("timeout_idle");

    // A key held through WAIT_RELEASE longer than the timeout must not fail
    exp_press.push_back(2'd3);
    expect_pass();
    f0 = fail_count;
    pulse_start(18'b11, 4'd1);
    press_key(3, 150, 10);
    check("release_no_timeout", 32'(fail_count), 32'(f0));
    wait_idle("release_idle");

    // length=0 behaves as a 1-tile round
    exp_press.push_back(2'd0);
    expect_pass();
    pulse_start(18'h0, 4'd0);
    press_key(0, 10, 10);
    wait_idle("len0_idle");

    // length=15 clamps to 9 tiles
    tiles9 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
    s9 = '0;
    for (int i = 0; i < 9; i++) begin
      s9[2*i +: 2] = tiles9[i];
      exp_press.push_back(tiles9[i]);
    end
    expect_pass();
    pulse_start(s9, 4'd15);
    p0 = pass_count;
    for (int i = 0; i < 8; i++) begin
      press_key(int'(tiles9[i]), 10, 10);
      if (i == 3) pulse_start(18'h0, 4'd1);
    end
    check("len15_no_early_pass", 32'(pass_count), 32'(p0));
    check("len15_index", 32'(cur_index), 8);
    press_key(int'(tiles9[8]), 10, 10);
    wait_idle("len15_idle");
    check("len15_pass", 32'(pass_count), 32'(p0 + 1));

    // Two keys debounced together: fail without press_valid
    expect_fail();
    pulse_start(18'h0, 4'd1);
    p0 = pv_count;
    key_n = 4'b1100; step(10);
    key_n = 4'b1111; step(10);
    check("multi_no_press", 32'(pv_count), 32'(p0));
    wait_idle("multi_idle");

    // Drive score to saturation, then one more passing round
    while (model_score < 255) begin
      exp_press.push_back(2'd0);
      expect_pass();
      pulse_start(18'h0, 4'd1);
      press_key(0, 8, 8);
      wait_idle("sat_fill");
    end
    check("sat_reach", 32'(score), 255);
    exp_press.push_back(2'd1);
    expect_pass();
    pulse_start(18'b01, 4'd1);
    press_key(1, 8, 8);
    wait_idle("sat_idle");
    check("sat_hold", 32'(score), 255);

    // Reset while in WAIT_RELEASE
    exp_press.push_back(2'd0);
    pulse_start(18'h0, 4'd2);
    p0 = pv_count;
    key_n[0] = 1'b0;
    n = 0;
    while (pv_count == p0 && n < 50) begin step(1); n++; end
    check("rst_mid_press", 32'(pv_count), 32'(p0 + 1));
    step(2);
    reset = 1'b1;
    step(1);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_score", 32'(score), 0);
    check("rst_mid_pass_fail", 32'({pass, fail}), 0);
    reset = 1'b0;
    model_score = 0;
    key_n = '1;
    p0 = pass_count; f0 = fail_count;
    step(20);
    check("rst_mid_quiet", 32'(pass_count + fail_count), 32'(p0 + f0));
    check("rst_mid_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
